// File: rtl/rand_mem_pkg.sv
// Shared defaults, request type and address helper for the random-access memory read pipe.
package rand_mem_pkg;

  localparam int unsigned RM_INDEX_WIDTH = 32;
  localparam int unsigned RM_ADDR_WIDTH  = 64;
  localparam int unsigned RM_DATA_WIDTH  = 64;
  localparam int unsigned RM_ELEM_SHIFT  = 3;
  localparam int unsigned RM_DEPTH       = 4;
  localparam int unsigned RM_TAG_WIDTH   = 8;

  // Wide enough for any supported base + shifted index before truncation to ADDR_WIDTH.
  localparam int unsigned RM_CALC_WIDTH  = 128;

  typedef logic [RM_CALC_WIDTH-1:0] calc_addr_t;

  typedef struct packed {
    logic [RM_ADDR_WIDTH-1:0] addr;
    logic [RM_TAG_WIDTH-1:0]  tag;
  } mem_req_t;

  function automatic calc_addr_t calc_addr(input calc_addr_t base, input calc_addr_t idx,
                                           input int unsigned shift);
    return base + (idx << shift);
  endfunction

endpackage

// File: rtl/rand_mem_read_pipe_sync_fifo.sv
// sync_fifo: DEPTH-entry synchronous FIFO (any DEPTH >= 1) with occupancy count and
// combinational head read; simultaneous push and pop is legal even when full.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/rand_mem_read_pipe.sv
// Index-to-address memory read stage with up to DEPTH reads in flight and in-order return.
// Optional sideband tag path enabled by defining RAND_MEM_READ_TAG_EN.
module rand_mem_read_pipe
  import rand_mem_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = RM_INDEX_WIDTH,
  parameter int unsigned ADDR_WIDTH  = RM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = RM_DATA_WIDTH,
  parameter int unsigned ELEM_SHIFT  = RM_ELEM_SHIFT,
  parameter int unsigned DEPTH       = RM_DEPTH,
  parameter int unsigned TAG_WIDTH   = RM_TAG_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_WIDTH-1:0]  base_addr_i,
  input  logic [INDEX_WIDTH-1:0] data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic                   mem_read,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_gnt,
  input  logic                   mem_resp,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic                   valid_o,
  output logic [DATA_WIDTH-1:0]  data_o,
  input  logic                   ready_i,
  output logic                   err_o
`ifdef RAND_MEM_READ_TAG_EN
  ,
  input  logic [TAG_WIDTH-1:0]   tag_i,
  output logic [TAG_WIDTH-1:0]   tag_o
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high
  // (valid_i/ready_o, mem_read/mem_gnt, valid_o/ready_i); a valid side holds its payload
  // stable until that cycle and never waits on its own ready before asserting valid.
  logic                  in_full;
  logic                  in_accept;
  logic                  req_fire;
  logic                  resp_accept;
  logic                  pop;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        inflight;
  logic                  data_full;
  logic                  data_empty;
  logic [ADDR_WIDTH-1:0] next_addr;

  assign next_addr = ADDR_WIDTH'(calc_addr(RM_CALC_WIDTH'(base_addr_i), RM_CALC_WIDTH'(data_i),
                                           ELEM_SHIFT));

`ifdef RAND_MEM_READ_TAG_EN
  // Request register carries the tag alongside the address; sized by the package defaults.
  mem_req_t req_q;
  assign mem_addr = ADDR_WIDTH'(req_q.addr);
`else
  logic [ADDR_WIDTH-1:0] req_q;
  assign mem_addr = req_q;
`endif

  assign inflight    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign mem_read    = in_full & (inflight < (CNT_W+1)'(DEPTH));
  assign req_fire    = mem_read & mem_gnt;
  assign ready_o     = ~in_full | req_fire;
  assign in_accept   = valid_i & ready_o;
  assign resp_accept = mem_resp & (outstanding != '0);
  assign valid_o     = ~data_empty;
  assign pop         = valid_o & ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_full     <= 1'b0;
      req_q       <= '0;
      outstanding <= '0;
      err_o       <= 1'b0;
    end else begin
      if (in_accept) begin
        in_full <= 1'b1;
`ifdef RAND_MEM_READ_TAG_EN
        req_q.addr <= RM_ADDR_WIDTH'(next_addr);
        req_q.tag  <= RM_TAG_WIDTH'(tag_i);
`else
        req_q <= next_addr;
`endif
      end else if (req_fire) begin
        in_full <= 1'b0;
      end
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(resp_accept);
      // A response with nothing outstanding is dropped and latched as an error.
      if (mem_resp && (outstanding == '0)) err_o <= 1'b1;
    end
  end

  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_data_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (resp_accept),
    .wdata (mem_rdata),
    .pop   (pop),
    .rdata (data_o),
    .count (fifo_count),
    .full  (data_full),
    .empty (data_empty)
  );

`ifdef RAND_MEM_READ_TAG_EN
  logic [CNT_W-1:0] tag_count;
  logic             tag_full;
  logic             tag_empty;

  // Tags enter at request fire, so the tag FIFO always tracks outstanding + buffered data.
  sync_fifo #(.WIDTH(TAG_WIDTH), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_fire),
    .wdata (TAG_WIDTH'(req_q.tag)),
    .pop   (pop),
    .rdata (tag_o),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (TAG_WIDTH <= RM_TAG_WIDTH);
      assert (!(data_full && resp_accept && !pop));
`ifdef RAND_MEM_READ_TAG_EN
      assert ({1'b0, tag_count} == inflight);
      assert (tag_empty == (inflight == '0));
      assert (!(tag_full && req_fire && !pop));
`endif
    end
  end

endmodule

// File: tb/tb_rand_mem_read_pipe.sv
// Directed self-checking bench for rand_mem_read_pipe with a 2-cycle in-order memory model.
`timescale 1ns/1ps
module tb_rand_mem_read_pipe;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 32;
  localparam int TW = 8;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] base_addr_i = '0;
  logic [IW-1:0] data_i      = '0;
  logic          valid_i     = 1'b0;
  logic          ready_o;
  logic          mem_read;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt     = 1'b1;
  logic          mem_resp    = 1'b0;
  logic [DW-1:0] mem_rdata   = '0;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          ready_i     = 1'b1;
  logic          err_o;
  logic [TW-1:0] tag_drv     = '0;
`ifdef RAND_MEM_READ_TAG_EN
  logic [TW-1:0] tag_o;
`endif

  rand_mem_read_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .base_addr_i (base_addr_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .mem_read    (mem_read),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_resp    (mem_resp),
    .mem_rdata   (mem_rdata),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .ready_i     (ready_i),
    .err_o       (err_o)
`ifdef RAND_MEM_READ_TAG_EN
    ,
    .tag_i       (tag_drv),
    .tag_o       (tag_o)
`endif
  );

  // scoreboard
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] out_q[$];
  logic [AW-1:0] fire_q[$];
  logic [TW-1:0] exp_tag_q[$];
  logic [TW-1:0] tag_q[$];
  logic [AW-1:0] pend_addr[$];
  int            pend_due[$];
  int            n_fire  = 0;
  int            cyc     = 0;
  int            mem_lat = 2;
  logic          err_req = 1'b0;
  int            checks  = 0;
  int            errors  = 0;

  function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
    return {a[31:0] ^ 32'hC001_D00D, ~a[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory model: drives responses 2ns after the edge, samples fires/pops 1ns before the edge.
  always begin
    @(posedge clk);
    #2;
    if (!rst_n) begin
      pend_addr.delete();
      pend_due.delete();
      mem_resp = 1'b0;
    end else if (err_req) begin
      mem_resp  = 1'b1;
      mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
    end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      mem_resp  = 1'b1;
      mem_rdata = rdata_of(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      mem_resp = 1'b0;
    end
    #7;
    if (rst_n) begin
      if (mem_read && mem_gnt) begin
        pend_addr.push_back(mem_addr);
        pend_due.push_back(cyc + mem_lat);
        fire_q.push_back(mem_addr);
        n_fire++;
      end
      if (valid_o && ready_i) begin
        out_q.push_back(data_o);
`ifdef RAND_MEM_READ_TAG_EN
        tag_q.push_back(tag_o);
`endif
      end
    end
    cyc++;
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic send(input logic [IW-1:0] idx, input logic [TW-1:0] tg);
    int n = 0;
    valid_i = 1'b1;
    data_i  = idx;
    tag_drv = tg;
    #4;
    while (!ready_o && n < 200) begin
      @(negedge clk);
      #4;
      n++;
    end
    if (n >= 200) check("send_accept", 64'(n), 64'(0));
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (out_q.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("out_count", 64'(out_q.size()), 64'(n));
  endtask

  task automatic compare_out(input string tag);
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) check(tag, out_q[i], exp_q[i]);
  endtask

  task automatic clear_logs();
    exp_q.delete();
    out_q.delete();
    fire_q.delete();
    exp_tag_q.delete();
    tag_q.delete();
    n_fire = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready_o"},  64'(ready_o),  64'(1));
    check({tag, "_mem_read"}, 64'(mem_read), 64'(0));
    check({tag, "_mem_addr"}, mem_addr,      64'(0));
    check({tag, "_valid_o"},  64'(valid_o),  64'(0));
    check({tag, "_data_o"},   data_o,        64'(0));
    check({tag, "_err_o"},    64'(err_o),    64'(0));
  endtask

  logic [AW-1:0] t1_addr[3] = '{64'h1000, 64'h1008, 64'h1028};
  logic [IW-1:0] t1_idx[3]  = '{32'd0, 32'd1, 32'd5};

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: base 0x1000, idx 0,1,5, gnt=1, 2-cycle memory
    clear_logs();
    base_addr_i = 64'h1000;
    for (int i = 0; i < 3; i++) begin
      send(t1_idx[i], '0);
      exp_q.push_back(rdata_of(t1_addr[i]));
    end
    wait_out(3);
    check("t1_fires", 64'(n_fire), 64'(3));
    for (int i = 0; i < 3 && i < fire_q.size(); i++) check("t1_addr", fire_q[i], t1_addr[i]);
    compare_out("t1_data");

    // 1b: address wrap at ADDR_WIDTH and zero-extension of the index
    clear_logs();
    base_addr_i = 64'hFFFF_FFFF_FFFF_FFF8;
    send(32'd2, '0);
    wait_out(1);
    base_addr_i = 64'h0;
    send(32'hFFFF_FFFF, '0);
    wait_out(2);
    check("t1b_addr_wrap", fire_q[0], 64'h8);
    check("t1b_addr_zext", fire_q[1], 64'h7_FFFF_FFF8);
    exp_q.push_back(rdata_of(64'h8));
    exp_q.push_back(rdata_of(64'h7_FFFF_FFF8));
    compare_out("t1b_data");

    // 2: consumer stalled, 8 tokens: only DEPTH reads may fire
    clear_logs();
    base_addr_i = 64'h2000;
    ready_i = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(rdata_of(64'h2000 + 64'(i) * 8));
    fork
      begin
        for (int i = 0; i < 8; i++) send(IW'(i), '0);
      end
    join_none
    repeat (12) @(negedge clk);
    check("t2_fires_full", 64'(n_fire), 64'(4));
    check("t2_mem_read",   64'(mem_read), 64'(0));
    check("t2_ready_o",    64'(ready_o),  64'(0));
    check("t2_valid_o",    64'(valid_o),  64'(1));
    check("t2_head",       data_o,        rdata_of(64'h2000));
    ready_i = 1'b1;
    wait fork;
    wait_out(8);
    check("t2_fires_all", 64'(n_fire), 64'(8));
    compare_out("t2_data");

    // 3: grant withheld: request held stable, then exactly one fire per grant cycle
    clear_logs();
    base_addr_i = 64'h3000;
    mem_gnt = 1'b0;
    send(32'd1, '0);
    fork
      send(32'd2, '0);
    join_none
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_read", 64'(mem_read), 64'(1));
      check("t3_hold_addr", mem_addr,      64'h3008);
      check("t3_hold_rdy",  64'(ready_o),  64'(0));
    end
    check("t3_no_fire", 64'(n_fire), 64'(0));
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("t3_one_fire",  64'(n_fire),   64'(1));
    check("t3_next_read", 64'(mem_read), 64'(1));
    check("t3_next_addr", mem_addr,      64'h3010);
    repeat (3) @(negedge clk);
    check("t3_still_one", 64'(n_fire),   64'(1));
    mem_gnt = 1'b1;
    wait fork;
    wait_out(2);
    exp_q.push_back(rdata_of(64'h3008));
    exp_q.push_back(rdata_of(64'h3010));
    compare_out("t3_data");

    // 4: spurious response with nothing outstanding
    clear_logs();
    check("t4_err_pre", 64'(err_o), 64'(0));
    @(posedge clk);
    #1 err_req = 1'b1;
    @(posedge clk);
    #1 err_req = 1'b0;
    @(negedge clk);
    check("t4_err_set",  64'(err_o),   64'(1));
    check("t4_valid_o",  64'(valid_o), 64'(0));
    repeat (5) @(negedge clk);
    check("t4_err_sticky", 64'(err_o),        64'(1));
    check("t4_no_output",  64'(out_q.size()), 64'(0));
    base_addr_i = 64'h4000;
    send(32'd3, '0);
    wait_out(1);
    exp_q.push_back(rdata_of(64'h4018));
    compare_out("t4_data");

    // 5: asynchronous reset with three reads in flight
    clear_logs();
    mem_lat = 8;
    base_addr_i = 64'h5000;
    for (int i = 0; i < 3; i++) send(IW'(i), '0);
    repeat (2) @(negedge clk);
    check("t5_inflight", 64'(n_fire), 64'(3));
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("t5_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mem_lat = 2;
    clear_logs();
    ready_i = 1'b0;
    base_addr_i = 64'h5100;
    for (int i = 0; i < 4; i++) exp_q.push_back(rdata_of(64'h5100 + 64'(i) * 8));
    fork
      begin
        for (int i = 0; i < 4; i++) send(IW'(i), '0);
      end
    join_none
    repeat (12) @(negedge clk);
    check("t5_credit", 64'(n_fire), 64'(4));
    check("t5_err_o",  64'(err_o),  64'(0));
    ready_i = 1'b1;
    wait fork;
    wait_out(4);
    compare_out("t5_data");

`ifdef RAND_MEM_READ_TAG_EN
    // 6: tags follow their data under random grant/consumer stalls
    clear_logs();
    base_addr_i = 64'h6000;
    exp_tag_q = '{8'hA1, 8'hB2, 8'hC3};
    for (int i = 1; i <= 3; i++) exp_q.push_back(rdata_of(64'h6000 + 64'(i) * 8));
    fork
      begin
        send(32'd1, 8'hA1);
        send(32'd2, 8'hB2);
        send(32'd3, 8'hC3);
      end
    join_none
    for (int t = 0; t < 300 && out_q.size() < 3; t++) begin
      @(negedge clk);
      mem_gnt = 1'($urandom_range(0, 1));
      ready_i = 1'($urandom_range(0, 1));
    end
    mem_gnt = 1'b1;
    ready_i = 1'b1;
    wait fork;
    wait_out(3);
    compare_out("t6_data");
    for (int i = 0; i < 3 && i < tag_q.size(); i++) check("t6_tag", 64'(tag_q[i]), 64'(exp_tag_q[i]));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
